// File: rtl/multi_voice_sound.sv
// Multi-voice square-wave sound generator.
// Each voice has a writable step pattern, a linear-decay envelope that is
// retriggered on note start, and a half-period tone counter clocked by
// scanlines. The enabled voices are summed and rendered as a 1-bit PWM
// pulse whose width grows with the mixed amplitude, measured in pixels
// from X_PWM_START on each scanline.
module multi_voice_sound #(
  parameter int NUM_VOICES      = 2,
  parameter int STEPS           = 16,
  parameter int DIV_W           = 8,
  parameter int ENV_W           = 5,
  parameter int DECAY           = 4,
  parameter int FRAMES_PER_STEP = 8,
  parameter int X_PWM_START     = 256,
  parameter int PWM_SHIFT       = 3,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            x,
  input  logic                  new_frame,
  input  logic                  enable,
  input  logic [NUM_VOICES-1:0] mute,
  input  logic                  cfg_we,
  input  logic [VW-1:0]         cfg_voice,
  input  logic [SW-1:0]         cfg_step,
  input  logic [DIV_W-1:0]      cfg_period,
  output logic                  sound,
  output logic [SW-1:0]         step,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int FW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int AMP_W = ENV_W + $clog2(NUM_VOICES) + 1;

  localparam logic [FW-1:0]    FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [ENV_W-1:0] ENV_MAX    = {ENV_W{1'b1}};
  localparam logic [31:0]      DECAY_U    = 32'(DECAY);
  localparam logic [31:0]      XS_U       = 32'(X_PWM_START);

  logic [FW-1:0] frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic          adv;

  logic [NUM_VOICES-1:0][ENV_W-1:0] contrib;
  logic [NUM_VOICES-1:0]            va_d;
  logic [NUM_VOICES-1:0]            va_q;

  logic [AMP_W-1:0] amp;
  logic [31:0]      pw;
  logic [31:0]      x_ext;
  logic             sound_d;
  logic             sound_q;

  // Frame counter and step sequencer; a step advance happens on the frame
  // that wraps the frame counter.
  always_comb begin
    frame_d = frame_q;
    step_d  = step_q;
    adv     = 1'b0;
    if (enable && new_frame) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        step_d  = step_q + SW'(1);
        adv     = 1'b1;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic [DIV_W-1:0] pat_q [STEPS];
    logic [DIV_W-1:0] period_q, period_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             phase_q, phase_d;

    // Tone divider per scanline, note latch on step advance, envelope decay
    // on plain frames (a retrigger takes precedence over decay).
    always_comb begin
      period_d = period_q;
      env_d    = env_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (enable && x == 10'd0) begin
        if (period_q == '0) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q >= period_q - DIV_W'(1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      if (adv) begin
        period_d = pat_q[step_d];
        if (period_d != '0) env_d = ENV_MAX;
      end else if (enable && new_frame) begin
        if (32'(env_q) > DECAY_U) env_d = env_q - ENV_W'(DECAY_U);
        else                      env_d = '0;
      end
    end

    // Voice state and pattern storage; the load above reads the old entry,
    // so a same-cycle write only shows up on the next visit to that step.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        period_q <= '0;
        env_q    <= '0;
        cnt_q    <= '0;
        phase_q  <= 1'b0;
        for (int s = 0; s < STEPS; s++) pat_q[s] <= '0;
      end else begin
        period_q <= period_d;
        env_q    <= env_d;
        cnt_q    <= cnt_d;
        phase_q  <= phase_d;
        if (cfg_we && cfg_voice == VW'(gi)) pat_q[cfg_step] <= cfg_period;
      end
    end

    assign contrib[gi] = (phase_q && !mute[gi] && period_q != '0) ? env_q : '0;
    assign va_d[gi]    = (env_d != '0) && (period_d != '0);
  end

  // Sum the audible voices; the accumulator is wide enough to never overflow.
  always_comb begin
    amp = '0;
    for (int v = 0; v < NUM_VOICES; v++) amp = amp + AMP_W'(contrib[v]);
  end

  // Pulse compare is done at 32 bits so a wide pulse clips at line end
  // instead of wrapping.
  assign pw      = 32'(amp) << PWM_SHIFT;
  assign x_ext   = 32'(x);
  assign sound_d = enable && (x_ext >= XS_U) && ((x_ext - XS_U) < pw);

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      step_q  <= '0;
      sound_q <= 1'b0;
      va_q    <= '0;
    end else begin
      frame_q <= frame_d;
      step_q  <= step_d;
      sound_q <= sound_d;
      va_q    <= va_d;
    end
  end

  assign sound        = sound_q;
  assign step         = step_q;
  assign voice_active = va_q;

endmodule
